// File: rtl/pipe_pkg.sv
// Shared ID/EX control-bundle layout and the bubble encoding used when no instruction is in flight.
package pipe_pkg;

  localparam logic [1:0] NEXT_PC   = 2'b00;
  localparam logic [1:0] BRANCH_PC = 2'b01;
  localparam logic [1:0] JUMP_PC   = 2'b10;

  typedef struct packed {
    logic       spare;
    logic       mem_read;
    logic [2:0] ls_mode;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       reg_write;
  } ctrl_t;

  localparam int CTRL_BITS       = $bits(ctrl_t);
  localparam int REG_WRITE_BIT   = 0;
  localparam int RESULT_SRC_LSB  = 1;
  localparam int MEM_WRITE_BIT   = 3;
  localparam int PC_SRC_LSB      = 4;
  localparam int ALU_CONTROL_LSB = 6;
  localparam int ALU_SRC_BIT     = 10;
  localparam int LS_MODE_LSB     = 11;
  localparam int MEM_READ_BIT    = 14;

  // A bubble must have no architectural side effects and fall through to the next PC.
  localparam ctrl_t CTRL_NOP = '{
    spare:       1'b0,
    mem_read:    1'b0,
    ls_mode:     3'd0,
    alu_src:     1'b0,
    alu_control: 4'd0,
    pc_src:      NEXT_PC,
    mem_write:   1'b0,
    result_src:  2'd0,
    reg_write:   1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/id_ex_skid_pipe.sv
// ID/EX pipeline register built as a two-entry skid buffer so in_ready never depends
// combinationally on out_ready; flush squashes everything held and in flight.
module id_ex_skid_pipe
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CTRL_WIDTH = 16,
  parameter logic [CTRL_WIDTH-1:0] NOP_CTRL   = CTRL_WIDTH'(CTRL_NOP),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  logic                  main_valid_reg, main_valid_next;
  logic [CTRL_WIDTH-1:0] main_ctrl_reg,  main_ctrl_next;
  logic [DATA_WIDTH-1:0] main_data_reg,  main_data_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic [CTRL_WIDTH-1:0] skid_ctrl_reg,  skid_ctrl_next;
  logic [DATA_WIDTH-1:0] skid_data_reg,  skid_data_next;
  logic                  in_ready_reg;

  logic accept;
  logic xfer;

  assign accept = in_valid & in_ready_reg;
  assign xfer   = main_valid_reg & out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_data_next  = skid_data_reg;

    if (flush) begin
      // Data registers are left alone: payload is don't-care under a bubble.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg) begin
      if (xfer) begin
        main_ctrl_next  = skid_ctrl_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (!main_valid_reg || xfer) begin
      main_valid_next = accept;
      if (accept) begin
        main_ctrl_next = in_ctrl;
        main_data_next = in_data;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_ctrl_next  = in_ctrl;
      skid_data_next  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= NOP_CTRL;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= NOP_CTRL;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_valid_reg <= main_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_data_reg  <= skid_data_next;
      in_ready_reg   <= !skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_ctrl  = main_valid_reg ? main_ctrl_reg : NOP_CTRL;
  assign out_data  = main_data_reg;

  // Index 0 counts stalled cycles, index 1 counts flushes that squash live state.
  logic [1:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_val [2];

  assign cnt_inc[0] = main_valid_reg & ~out_ready;
  assign cnt_inc[1] = flush & (main_valid_reg | skid_valid_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH(CNT_WIDTH)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(1'b0),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_id_ex_skid_pipe.sv
// Bench for id_ex_skid_pipe: directed scenarios plus random traffic against a 2-deep FIFO model.
module tb_id_ex_skid_pipe;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, flush_cnt;

  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4, flush_cnt4;

  id_ex_skid_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_skid_pipe #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
    .out_data(out_data4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t         q[$];
  int            m_stall;
  int            m_flush;
  logic [DW-1:0] m_last;

  task automatic model_reset();
    q.delete();
    m_stall = 0;
    m_flush = 0;
    m_last  = '0;
  endtask

  // Advance one clock; the model sees the same pre-edge inputs as the DUT.
  task automatic step();
    bit    acc;
    bit    xf;
    item_t it;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush && q.size() > 0 && m_flush < 65535) m_flush++;
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        xf  = (q.size() > 0) && out_ready;
        if (xf) void'(q.pop_front());
        if (acc) begin
          it.c = in_ctrl;
          it.d = in_data;
          q.push_back(it);
        end
      end
      if (q.size() > 0) m_last = q[0].d;
    end
    #1;
  endtask

  function automatic logic [CW-1:0] exp_ctrl();
    logic [CW-1:0] nop;
    nop = CTRL_NOP;
    return (q.size() > 0) ? q[0].c : nop;
  endfunction

  task automatic test_reset();
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_ctrl !== CW'(CTRL_NOP)) $display("FAIL reset_out_ctrl got=%h exp=%h", out_ctrl, CW'(CTRL_NOP)); else passed++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else passed++;
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL reset_counters got=%0d,%0d exp=0,0", stall_cnt, flush_cnt); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] bd [3];
    logic [CW-1:0] bc [3];
    bd = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    bc = '{16'h1235, 16'h2346, 16'h3457};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = bc[i]; in_data = bd[i];
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== bd[i] || out_ctrl !== bc[i])
        $display("FAIL b2b_item%0d got v=%b d=%h c=%h exp v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, bd[i], bc[i]);
      else passed++;
      checks++; if (in_ready !== 1'b1 || stall_cnt !== 16'd0)
        $display("FAIL b2b_ready_stall%0d got rdy=%b stall=%0d exp rdy=1 stall=0", i, in_ready, stall_cnt);
      else passed++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== bd[2])
      $display("FAIL b2b_drain got v=%b d=%h exp v=0 d=%h", out_valid, out_data, bd[2]);
    else passed++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0AA1; in_data = 32'h1111_AAAA;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1111_AAAA || in_ready !== 1'b1)
      $display("FAIL skid_load_a got v=%b d=%h rdy=%b exp v=1 d=1111aaaa rdy=1", out_valid, out_data, in_ready);
    else passed++;
    in_ctrl = 16'h0BB2; in_data = 32'h2222_BBBB;
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'h1111_AAAA || stall_cnt !== 16'd1)
      $display("FAIL skid_load_b got rdy=%b d=%h stall=%0d exp rdy=0 d=1111aaaa stall=1", in_ready, out_data, stall_cnt);
    else passed++;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (stall_cnt !== 16'(2 + k) || in_ready !== 1'b0)
        $display("FAIL skid_stall%0d got stall=%0d rdy=%b exp stall=%0d rdy=0", k, stall_cnt, in_ready, 2 + k);
      else passed++;
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h2222_BBBB || out_ctrl !== 16'h0BB2 || in_ready !== 1'b1)
      $display("FAIL skid_release_b got v=%b d=%h c=%h rdy=%b exp v=1 d=2222bbbb c=0bb2 rdy=1", out_valid, out_data, out_ctrl, in_ready);
    else passed++;
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd4)
      $display("FAIL skid_empty got v=%b stall=%0d exp v=0 stall=4", out_valid, stall_cnt);
    else passed++;
  endtask

  task automatic test_flush();
    ctrl_t oc;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h7FFF; in_data = 32'h3333_0001;
    step();
    in_data = 32'h3333_0002;
    step();
    in_data = 32'h3333_0003; flush = 1'b1;
    step();
    oc = ctrl_t'(out_ctrl);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== CW'(CTRL_NOP))
      $display("FAIL flush_bubble got v=%b c=%h exp v=0 c=%h", out_valid, out_ctrl, CW'(CTRL_NOP));
    else passed++;
    checks++; if (oc.reg_write !== 1'b0 || oc.mem_write !== 1'b0 || oc.pc_src !== NEXT_PC)
      $display("FAIL flush_fields got rw=%b mw=%b pc=%b exp rw=0 mw=0 pc=%b", oc.reg_write, oc.mem_write, oc.pc_src, NEXT_PC);
    else passed++;
    checks++; if (in_ready !== 1'b1 || flush_cnt !== 16'd1 || out_data !== 32'h3333_0001)
      $display("FAIL flush_state got rdy=%b fcnt=%0d d=%h exp rdy=1 fcnt=1 d=33330001", in_ready, flush_cnt, out_data);
    else passed++;
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || flush_cnt !== 16'd1)
      $display("FAIL flush_dropped_incoming got v=%b fcnt=%0d exp v=0 fcnt=1", out_valid, flush_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h1001; in_data = 32'h4444_0001;
    step();
    in_data = 32'h4444_0002;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== CW'(CTRL_NOP))
      $display("FAIL arst_handshake got v=%b rdy=%b c=%h exp v=0 rdy=1 c=%h", out_valid, in_ready, out_ctrl, CW'(CTRL_NOP));
    else passed++;
    checks++; if (out_data !== '0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt4 !== 4'd0)
      $display("FAIL arst_data_cnt got d=%h s=%0d f=%0d s4=%0d exp all 0", out_data, stall_cnt, flush_cnt, stall_cnt4);
    else passed++;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0C0C; in_data = 32'h5555_00AA;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5555_00AA || in_ready !== 1'b1)
      $display("FAIL arst_x_lands got v=%b d=%h rdy=%b exp v=1 d=555500aa rdy=1", out_valid, out_data, in_ready);
    else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0)
      $display("FAIL arst_x_alone got v=%b exp v=0", out_valid);
    else passed++;
  endtask

  task automatic test_saturation();
    int e4;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h00F0; in_data = 32'h6666_6666;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      e4 = (k < 15) ? k : 15;
      checks++; if (stall_cnt4 !== 4'(e4) || stall_cnt !== 16'(k))
        $display("FAIL sat_stall%0d got s4=%0d s=%0d exp s4=%0d s=%0d", k, stall_cnt4, stall_cnt, e4, k);
      else passed++;
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    int e4;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = $urandom;
      step();
      e4 = (m_stall < 15) ? m_stall : 15;
      checks++; if (out_valid !== (q.size() > 0) || out_valid4 !== (q.size() > 0))
        $display("FAIL rnd_valid n=%0d got %b/%b exp %b", n, out_valid, out_valid4, q.size() > 0);
      else passed++;
      checks++; if (in_ready !== (q.size() < 2))
        $display("FAIL rnd_ready n=%0d got %b exp %b", n, in_ready, q.size() < 2);
      else passed++;
      checks++; if (out_ctrl !== exp_ctrl() || out_data !== m_last)
        $display("FAIL rnd_payload n=%0d got c=%h d=%h exp c=%h d=%h", n, out_ctrl, out_data, exp_ctrl(), m_last);
      else passed++;
      checks++; if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) || stall_cnt4 !== 4'(e4))
        $display("FAIL rnd_counters n=%0d got s=%0d f=%0d s4=%0d exp s=%0d f=%0d s4=%0d", n, stall_cnt, flush_cnt, stall_cnt4, m_stall, m_flush, e4);
      else passed++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_skid();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_skid_pipe.md
ID_EX_SKID_PIPE -- requirements
Module: id_ex_skid_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data payload (operands, PC, PC+4, immediate, register indices packed by the caller).
REQ-002 SHALL have parameter CTRL_WIDTH, default 16: width of the packed control bundle (RegWrite, ResultSrc, MemWrite, PCsrc, ALUControl, ALUsrc, LS_mode, MemRead).
REQ-003 SHALL have parameter NOP_CTRL, default from package constant CTRL_NOP: control bundle presented for a bubble, with RegWrite=0, MemWrite=0, MemRead=0, PCsrc=NEXT_PC.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  decode stage offers an instruction.
REQ-008 in_ready  out  1  stage can accept; registered.
REQ-009 in_ctrl  in  CTRL_WIDTH  decode control bundle.
REQ-010 in_data  in  DATA_WIDTH  decode data payload.
REQ-011 flush  in  1  squash all held and incoming instructions.
REQ-012 out_valid  out  1  execute-side instruction valid.
REQ-013 out_ready  in  1  execute stage consumes this cycle.
REQ-014 out_ctrl  out  CTRL_WIDTH  control bundle; NOP_CTRL whenever out_valid=0.
REQ-015 out_data  out  DATA_WIDTH  data payload; holds last value when out_valid=0.
REQ-016 stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.
REQ-017 flush_cnt  out  CNT_WIDTH  cycles with flush=1 while at least one entry valid.

Function
REQ-018 Two-entry skid buffer: main register (drives outputs) plus one skid register; no combinational path from out_ready to in_ready.
REQ-019 Accept = in_valid & in_ready; transfer = out_valid & out_ready; in_ready = !skid_valid, registered.
REQ-020 Main empty or transferring, skid empty: accepted item loads main next cycle (latency 1).
REQ-021 Main full, not transferring, accept: item loads skid; in_ready drops next cycle.
REQ-022 Skid full and main transfers: skid moves to main, skid empties, in_ready rises next cycle.
REQ-023 Ordering SHALL be strictly FIFO; no item duplicated or dropped except by flush.
REQ-024 flush SHALL clear main and skid valid next cycle, discard any same-cycle accept, force out_ctrl=NOP_CTRL, set in_ready=1; flush has priority over every other event.
REQ-025 Counters SHALL increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
REQ-026 out_data SHALL not be cleared by flush (data is don't-care under bubble).

Reset
REQ-027 rst SHALL asynchronously force: out_valid=0, skid_valid=0, in_ready=1, out_ctrl=NOP_CTRL, out_data=0, stall_cnt=0, flush_cnt=0.
REQ-028 rst mid-transfer SHALL drop all held items; first accept after deassertion lands in main.

Structure
REQ-029 Package pipe_pkg SHALL hold CTRL_NOP, the NEXT_PC encoding, and the packed control-bundle typedef with field offsets.
REQ-030 One sub-module, sat_counter (parametrised width, inc, clear), SHALL implement both counters.

Verification
REQ-031 Reset then in_valid=1, out_ready=1, three items A,B,C back to back -> out_valid from cycle 1, A,B,C in order, in_ready stays 1, stall_cnt=0.
REQ-032 Main holds A, out_ready=0, accept B -> B in skid, in_ready=0 next cycle, stall_cnt increments each stalled cycle; out_ready=1 -> A then B, in_ready=1 again.
REQ-033 Both entries full plus in_valid=1 with flush=1 -> next cycle out_valid=0, out_ctrl=NOP_CTRL (RegWrite=0, MemWrite=0, PCsrc=NEXT_PC), in_ready=1, flush_cnt=1, incoming item absent.
REQ-034 CNT_WIDTH=4, out_ready=0 for 20 cycles with valid item -> stall_cnt saturates at 15.
REQ-035 rst asserted asynchronously between edges with skid full -> outputs reach reset values immediately; post-reset item X appears alone after 1 cycle.
